// File: rtl/fluxo_dados_param.sv
// fluxo_dados_param: datapath for a switch-memory game.
// Contains an address counter and a limit counter, a switch register,
// a DEPTH x WIDTH memory with a synchronous write-first read, new-press
// detection, and an optional timeout counter.
// Build option: define FLUXO_DADOS_TIMEOUT_EN to include the timeout counter.
// Without it, timeout is tied low and zeraT/contaT are ignored.
module fluxo_dados_param #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 5000,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] chaves,
    input  logic             zeraE,
    input  logic             contaE,
    input  logic             zeraL,
    input  logic             contaL,
    input  logic             zeraR,
    input  logic             registraR,
    input  logic             escreveM,
    input  logic             zeraT,
    input  logic             contaT,
    output logic             chavesIgualMemoria,
    output logic             enderecoIgualLimite,
    output logic             enderecoMenorLimite,
    output logic             fimE,
    output logic             fimL,
    output logic             jogada_feita,
    output logic             timeout,
    output logic [AW-1:0]    db_contagem,
    output logic [AW-1:0]    db_limite,
    output logic [WIDTH-1:0] db_chaves,
    output logic [WIDTH-1:0] db_memoria
);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    ONE_ADDR  = AW'(1);
    localparam logic [AW-1:0]    ZERO_ADDR = {AW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_DATA = {WIDTH{1'b0}};

    logic [AW-1:0]    addr_r;
    logic [AW-1:0]    limit_r;
    logic [WIDTH-1:0] chaves_r;
    logic [WIDTH-1:0] mem_rd_r;
    logic             prev_nz_r;
    logic             jogada_r;
    logic             chaves_nz_s;

    // Contents start cleared at configuration; reset deliberately leaves them alone.
    logic [WIDTH-1:0] mem_r [DEPTH] = '{default: {WIDTH{1'b0}}};

    // Address counter: clear wins over increment, wraps from DEPTH-1 to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r <= ZERO_ADDR;
        end else if (zeraE) begin
            addr_r <= ZERO_ADDR;
        end else if (contaE) begin
            addr_r <= (addr_r == LAST_ADDR) ? ZERO_ADDR : addr_r + ONE_ADDR;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Limit counter: same behaviour as the address counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            limit_r <= ZERO_ADDR;
        end else if (zeraL) begin
            limit_r <= ZERO_ADDR;
        end else if (contaL) begin
            limit_r <= (limit_r == LAST_ADDR) ? ZERO_ADDR : limit_r + ONE_ADDR;
        end else begin
            limit_r <= limit_r;
        end
    end

    // Switch register: clear wins over load.
    always_ff @(posedge clock) begin
        if (reset) begin
            chaves_r <= ZERO_DATA;
        end else if (zeraR) begin
            chaves_r <= ZERO_DATA;
        end else if (registraR) begin
            chaves_r <= chaves;
        end else begin
            chaves_r <= chaves_r;
        end
    end

    // Memory write port; a reset cycle suppresses the write.
    always_ff @(posedge clock) begin
        if (escreveM && !reset) begin
            mem_r[addr_r] <= chaves_r;
        end
    end

    // Synchronous read; a same-cycle write forwards the new data (write-first).
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_rd_r <= ZERO_DATA;
        end else if (escreveM) begin
            mem_rd_r <= chaves_r;
        end else begin
            mem_rd_r <= mem_r[addr_r];
        end
    end

    // Detect any switch being pressed in this cycle.
    always_comb begin
        chaves_nz_s = 1'b0;
        chaves_nz_s = (chaves != ZERO_DATA);
    end

    // New-press detector: one-cycle pulse when the switches go from zero to nonzero.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_nz_r <= 1'b0;
            jogada_r  <= 1'b0;
        end else begin
            prev_nz_r <= chaves_nz_s;
            jogada_r  <= chaves_nz_s & ~prev_nz_r;
        end
    end

    // Status compares on the registered values.
    always_comb begin
        fimE                = 1'b0;
        fimL                = 1'b0;
        enderecoIgualLimite = 1'b0;
        enderecoMenorLimite = 1'b0;
        chavesIgualMemoria  = 1'b0;
        fimE                = (addr_r == LAST_ADDR);
        fimL                = (limit_r == LAST_ADDR);
        enderecoIgualLimite = (addr_r == limit_r);
        enderecoMenorLimite = (addr_r < limit_r);
        chavesIgualMemoria  = (chaves_r == mem_rd_r);
    end

    assign db_contagem  = addr_r;
    assign db_limite    = limit_r;
    assign db_chaves    = chaves_r;
    assign db_memoria   = mem_rd_r;
    assign jogada_feita = jogada_r;

`ifdef FLUXO_DADOS_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_ZERO = {TW{1'b0}};

    logic [TW-1:0] to_cnt_r;

    // Timeout counter: clear wins, counts while enabled, sticks at TIMEOUT-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_r <= TO_ZERO;
        end else if (zeraT) begin
            to_cnt_r <= TO_ZERO;
        end else if (contaT && (to_cnt_r != TO_LAST)) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout = (to_cnt_r == TO_LAST);
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^{zeraT, contaT, (TIMEOUT > 1)};
    assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed self-checking bench for fluxo_dados_param (WIDTH=4, DEPTH=16, TIMEOUT=8).
module tb_fluxo_dados_param;

    localparam int W  = 4;
    localparam int D  = 16;
    localparam int T  = 8;
    localparam int AW = 4;

`ifdef FLUXO_DADOS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // control word bit order: {zeraE,contaE,zeraL,contaL,zeraR,registraR,escreveM,zeraT,contaT}
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_ZE   = 9'b100000000;
    localparam logic [8:0] C_CE   = 9'b010000000;
    localparam logic [8:0] C_ZL   = 9'b001000000;
    localparam logic [8:0] C_CL   = 9'b000100000;
    localparam logic [8:0] C_ZR   = 9'b000010000;
    localparam logic [8:0] C_RR   = 9'b000001000;
    localparam logic [8:0] C_WM   = 9'b000000100;
    localparam logic [8:0] C_ZT   = 9'b000000010;
    localparam logic [8:0] C_CT   = 9'b000000001;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  chaves = 4'h0;
    logic          zeraE = 1'b0, contaE = 1'b0, zeraL = 1'b0, contaL = 1'b0;
    logic          zeraR = 1'b0, registraR = 1'b0, escreveM = 1'b0;
    logic          zeraT = 1'b0, contaT = 1'b0;
    logic          chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite;
    logic          fimE, fimL, jogada_feita, timeout;
    logic [AW-1:0] db_contagem, db_limite;
    logic [W-1:0]  db_chaves, db_memoria;

    int total = 0;
    int bad   = 0;

    // flags order: {chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite, fimE, fimL, jogada_feita, timeout}
    typedef struct {
        string      name;
        logic [3:0] chv_in;
        logic [8:0] ctl;
        logic [3:0] e_cont;
        logic [3:0] e_lim;
        logic [3:0] e_chv;
        logic [3:0] e_mem;
        logic [6:0] e_flags;
    } vec_t;

    vec_t vecs [19];

    always #5 clock = ~clock;

    fluxo_dados_param #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .chaves(chaves),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
        .zeraT(zeraT), .contaT(contaT),
        .chavesIgualMemoria(chavesIgualMemoria),
        .enderecoIgualLimite(enderecoIgualLimite),
        .enderecoMenorLimite(enderecoMenorLimite),
        .fimE(fimE), .fimL(fimL), .jogada_feita(jogada_feita), .timeout(timeout),
        .db_contagem(db_contagem), .db_limite(db_limite),
        .db_chaves(db_chaves), .db_memoria(db_memoria)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ctl(input logic [8:0] c);
        {zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, zeraT, contaT} = c;
    endtask

    function automatic logic [6:0] flags();
        return {chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite,
                fimE, fimL, jogada_feita, timeout};
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_cont"}, 32'(db_contagem), 32'd0);
        chk({tag, "_lim"}, 32'(db_limite), 32'd0);
        chk({tag, "_chv"}, 32'(db_chaves), 32'd0);
        chk({tag, "_mem"}, 32'(db_memoria), 32'd0);
        chk({tag, "_flags"}, 32'(flags()), 32'(7'b1100000));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"a1",       4'h0, C_CE,               4'd1, 4'd0, 4'h0, 4'h0, 7'b1000000};
        vecs[1]  = '{"a2",       4'h0, C_CE,               4'd2, 4'd0, 4'h0, 4'h0, 7'b1000000};
        vecs[2]  = '{"a3",       4'h0, C_CE,               4'd3, 4'd0, 4'h0, 4'h0, 7'b1000000};
        vecs[3]  = '{"load0101", 4'h5, C_RR,               4'd3, 4'd0, 4'h5, 4'h0, 7'b0000010};
        vecs[4]  = '{"write3",   4'h5, C_WM,               4'd3, 4'd0, 4'h5, 4'h5, 7'b1000000};
        vecs[5]  = '{"zeraE",    4'h5, C_ZE,               4'd0, 4'd0, 4'h5, 4'h5, 7'b1100000};
        vecs[6]  = '{"b1",       4'h5, C_CE,               4'd1, 4'd0, 4'h5, 4'h0, 7'b0000000};
        vecs[7]  = '{"b2",       4'h5, C_CE,               4'd2, 4'd0, 4'h5, 4'h0, 7'b0000000};
        vecs[8]  = '{"b3",       4'h5, C_CE,               4'd3, 4'd0, 4'h5, 4'h0, 7'b0000000};
        vecs[9]  = '{"rd3",      4'h5, C_NONE,             4'd3, 4'd0, 4'h5, 4'h5, 7'b1000000};
        vecs[10] = '{"load0110", 4'h6, C_RR,               4'd3, 4'd0, 4'h6, 4'h5, 7'b0000000};
        vecs[11] = '{"multi",    4'h6, C_ZE | C_ZR | C_CL, 4'd0, 4'd1, 4'h0, 4'h5, 7'b0010000};
        vecs[12] = '{"lim2",     4'h6, C_CL,               4'd0, 4'd2, 4'h0, 4'h0, 7'b1010000};
        vecs[13] = '{"c1",       4'h6, C_CE,               4'd1, 4'd2, 4'h0, 4'h0, 7'b1010000};
        vecs[14] = '{"c2",       4'h6, C_CE,               4'd2, 4'd2, 4'h0, 4'h0, 7'b1100000};
        vecs[15] = '{"ze_pri",   4'h6, C_CE | C_ZE,        4'd0, 4'd2, 4'h0, 4'h0, 7'b1010000};
        vecs[16] = '{"zr_pri",   4'h6, C_RR | C_ZR,        4'd0, 4'd2, 4'h0, 4'h0, 7'b1010000};
        vecs[17] = '{"release",  4'h0, C_NONE,             4'd0, 4'd2, 4'h0, 4'h0, 7'b1010000};
        vecs[18] = '{"press",    4'h3, C_NONE,             4'd0, 4'd2, 4'h0, 4'h0, 7'b1010010};

        #2;
        // reset state
        do_reset();
        check_reset_state("rst0");

        // table: memory write/read, compares, priorities, simultaneous controls
        for (int i = 0; i < 19; i++) begin
            chaves = vecs[i].chv_in;
            set_ctl(vecs[i].ctl);
            tick();
            chk({vecs[i].name, "_cont"}, 32'(db_contagem), 32'(vecs[i].e_cont));
            chk({vecs[i].name, "_lim"}, 32'(db_limite), 32'(vecs[i].e_lim));
            chk({vecs[i].name, "_chv"}, 32'(db_chaves), 32'(vecs[i].e_chv));
            chk({vecs[i].name, "_mem"}, 32'(db_memoria), 32'(vecs[i].e_mem));
            chk({vecs[i].name, "_flags"}, 32'(flags()), 32'(vecs[i].e_flags));
        end

        // reset beats every control; switches held nonzero through it
        chaves = 4'hF;
        set_ctl(C_CE | C_CL | C_RR | C_CT);
        reset = 1'b1;
        tick();
        check_reset_state("rst_pri");
        reset = 1'b0;
        set_ctl(C_NONE);
        tick();
        chk("rst_release_pulse", 32'(jogada_feita), 32'd1);
        tick();
        chk("rst_release_nopulse", 32'(jogada_feita), 32'd0);

        // memory survives reset: read back address 3
        chaves = 4'h0;
        set_ctl(C_CE);
        tick(); tick(); tick();
        set_ctl(C_NONE);
        tick();
        chk("mem_keep_addr", 32'(db_contagem), 32'd3);
        chk("mem_keep_data", 32'(db_memoria), 32'h5);

        // full count and wrap on both counters
        do_reset();
        set_ctl(C_CE | C_CL);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("wrap_cont", 32'(db_contagem), 32'((i + 1) % 16));
            chk("wrap_lim", 32'(db_limite), 32'((i + 1) % 16));
            chk("wrap_fimE", 32'(fimE), 32'(((i + 1) % 16) == 15));
            chk("wrap_fimL", 32'(fimL), 32'(((i + 1) % 16) == 15));
        end
        set_ctl(C_NONE);

        // press detection: one pulse per zero-to-nonzero transition
        do_reset();
        chaves = 4'h0;
        tick();
        chk("press_idle", 32'(jogada_feita), 32'd0);
        chaves = 4'h2;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("press_hold", 32'(jogada_feita), 32'(k == 0));
        end
        chaves = 4'h0;
        tick();
        chk("press_rel", 32'(jogada_feita), 32'd0);
        chaves = 4'h8;
        tick();
        chk("press2", 32'(jogada_feita), 32'd1);
        tick();
        chk("press2_end", 32'(jogada_feita), 32'd0);
        chaves = 4'h0;

        // timeout: reaches TIMEOUT-1 after 7 counts, saturates, cleared by zeraT
        do_reset();
        set_ctl(C_CT);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("to_count", 32'(timeout), 32'(TO_EN && (k >= T - 1)));
        end
        set_ctl(C_ZT | C_CT);
        tick();
        chk("to_clear", 32'(timeout), 32'd0);
        set_ctl(C_CT);
        tick();
        chk("to_restart", 32'(timeout), 32'd0);
        set_ctl(C_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
